pipe_stall_ctrl: RTL and testbench

//   Pipeline stall/flush controller for the 6-stage MIPS core; successor to the fixed-mask controller.

---
 rtl/pipe_stall_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stall_ctrl
//  Purpose  : Stall/flush controller for the 6-stage MIPS pipeline. Drives the
//             per-stage hold (stall) and clear (flush) enables of the pipeline
//             registers and sequences multi-cycle MUL/DIV operations with a
//             down-counter that can be cut short by the unit's md_ready.
//  Ports    : clk, rst            clock (rising edge), synchronous active-high
//                                 reset
//             stallreq_id         load-use hazard request  -> stalls [ID:0]
//             stallreq_ex         generic EX request       -> stalls [EX:0]
//             mul_start/div_start MUL/DIV op present in EX (sampled in IDLE)
//             md_ready            mul/div result valid (early completion)
//             flush_req           exception/eret flush, highest priority
//             stall, flush        per-stage enables, bit0=PC ... bit5=WB
//             md_busy, md_done    FSM in MUL/DIV; 1-cycle completion pulse
//             perf_stall_cnt      cycles with any stall bit set
//             perf_md_cnt         cycles with md_busy set
//  Options  : define STALL_PERF_CNT_EN to build the saturating performance
//             counters; otherwise both perf ports are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stall_ctrl #(
  parameter int STAGES     = 6,
  parameter int ID_STAGE   = 2,
  parameter int EX_STAGE   = 3,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              mul_start,
  input  logic              div_start,
  input  logic              md_ready,
  input  logic              flush_req,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic              md_busy,
  output logic              md_done,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_md_cnt
);

  // The issuing cycle in IDLE is itself a stalled cycle, so the counter is
  // loaded with (cycles-1) and the op completes when it reaches zero.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [STAGES-1:0]  m_id;
  logic [STAGES-1:0]  m_ex;
  logic [STAGES-1:0]  m_all;
  logic               md_stall;
  logic               md_done_c;
  logic [STAGES-1:0]  stall_c;

  // --------------------------------------------------------------------------
  // Stage masks: a request from stage k holds every stage from PC up to k.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_mask
    assign m_id[gi]  = (gi <= ID_STAGE);
    assign m_ex[gi]  = (gi <= EX_STAGE);
    assign m_all[gi] = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Next-state / md control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_stall  = 1'b0;
    md_done_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        // MUL wins when both starts are seen together; the DIV is dropped.
        if (mul_start) begin
          md_stall = 1'b1;
          if (MUL_CYCLES == 1) begin
            md_done_c = 1'b1;
          end else begin
            state_d = S_MUL;
            cnt_d   = MUL_LOAD;
          end
        end else if (div_start) begin
          md_stall = 1'b1;
          if (DIV_CYCLES == 1) begin
            md_done_c = 1'b1;
          end else begin
            state_d = S_DIV;
            cnt_d   = DIV_LOAD;
          end
        end
      end

      S_MUL, S_DIV: begin
        // New starts are ignored here: no restart, no counter reload.
        if ((cnt_q == '0) || md_ready) begin
          md_done_c = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else begin
          md_stall = 1'b1;
          cnt_d    = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A flush aborts any op in flight and suppresses its completion pulse.
    if (flush_req) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      md_stall  = 1'b0;
      md_done_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: combinational so the stall lands in the same cycle as the
  // request. The EX mask is a superset of the ID mask, so it simply wins.
  // --------------------------------------------------------------------------
  always_comb begin
    stall_c = '0;
    if (!flush_req) begin
      if (md_stall || stallreq_ex) begin
        stall_c = m_ex;
      end else if (stallreq_id) begin
        stall_c = m_id;
      end
    end
  end

  assign stall   = rst ? '0 : stall_c;
  assign flush   = (rst || !flush_req) ? '0 : m_all;
  assign md_busy = !rst && ((state_q == S_MUL) || (state_q == S_DIV));
  assign md_done = !rst && md_done_c;

  // --------------------------------------------------------------------------
  // Performance counters (optional)
  // --------------------------------------------------------------------------
`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_md_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_md_q    <= '0;
    end else begin
      if ((stall != '0) && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (md_busy && (perf_md_q != 32'hFFFF_FFFF)) begin
        perf_md_q <= perf_md_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_md_cnt    = perf_md_q;
`else
  assign perf_stall_cnt = 32'h0;
  assign perf_md_cnt    = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stall_ctrl
//  Purpose  : Self-checking bench for pipe_stall_ctrl. Each driven cycle pushes
//             its expected outputs to a queue; a monitor on the falling edge
//             pops them and compares against the DUT.
//  Options  : honours STALL_PERF_CNT_EN for the expected perf counter values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        mul_start = 1'b0;
  logic        div_start = 1'b0;
  logic        md_ready = 1'b0;
  logic        flush_req = 1'b0;
  logic [5:0]  stall;
  logic [5:0]  flush;
  logic        md_busy;
  logic        md_done;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_md_cnt;

  pipe_stall_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id    (stallreq_id),
    .stallreq_ex    (stallreq_ex),
    .mul_start      (mul_start),
    .div_start      (div_start),
    .md_ready       (md_ready),
    .flush_req      (flush_req),
    .stall          (stall),
    .flush          (flush),
    .md_busy        (md_busy),
    .md_done        (md_done),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_md_cnt    (perf_md_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  stall;
    logic [5:0]  flush;
    logic        busy;
    logic        done;
    logic        pchk;
    logic [31:0] ps;
    logic [31:0] pm;
    logic [7:0]  id;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  cur_id   = 8'd0;
  logic        pend_pchk = 1'b0;
  logic [31:0] pend_ps   = 32'd0;
  logic [31:0] pend_pm   = 32'd0;

  localparam logic [5:0] S0  = 6'b000000;
  localparam logic [5:0] SID = 6'b000111;
  localparam logic [5:0] SEX = 6'b001111;
  localparam logic [5:0] FAL = 6'b111111;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // in = {rst, stallreq_id, stallreq_ex, mul_start, div_start, md_ready, flush_req}
  task automatic step(input logic [6:0] in, input logic [5:0] es, input logic [5:0] ef,
                      input logic eb, input logic ed);
    exp_t e;
    @(posedge clk);
    #1;
    {rst, stallreq_id, stallreq_ex, mul_start, div_start, md_ready, flush_req} = in;
    e.stall = es;
    e.flush = ef;
    e.busy  = eb;
    e.done  = ed;
    e.pchk  = pend_pchk;
    e.ps    = pend_ps;
    e.pm    = pend_pm;
    e.id    = cur_id;
    sb.push_back(e);
    pend_pchk = 1'b0;
  endtask

  task automatic expect_perf(input logic [31:0] ps, input logic [31:0] pm);
`ifdef STALL_PERF_CNT_EN
    pend_ps = ps;
    pend_pm = pm;
`else
    pend_ps = 32'd0 & ps;
    pend_pm = 32'd0 & pm;
`endif
    pend_pchk = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check($sformatf("t%0d.stall", e.id), 32'(stall),   32'(e.stall));
      check($sformatf("t%0d.flush", e.id), 32'(flush),   32'(e.flush));
      check($sformatf("t%0d.busy",  e.id), 32'(md_busy), 32'(e.busy));
      check($sformatf("t%0d.done",  e.id), 32'(md_done), 32'(e.done));
      if (e.pchk) begin
        check($sformatf("t%0d.perf_stall", e.id), perf_stall_cnt, e.ps);
        check($sformatf("t%0d.perf_md",    e.id), perf_md_cnt,    e.pm);
      end
    end
  end

  initial begin
    // Reset: outputs forced low even with requests present.
    cur_id = 8'd0;
    step(7'b1_011_000, S0, S0, 1'b0, 1'b0);
    expect_perf(32'd0, 32'd0);
    step(7'b1_110_001, S0, S0, 1'b0, 1'b0);

    // Test 1: MUL, no md_ready: 5 stalled cycles, done in the 6th.
    cur_id = 8'd1;
    step(7'b0_001_000, SEX, S0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(7'b0_000_000, SEX, S0, 1'b1, 1'b0);
    expect_perf(32'd5, 32'd4);
    step(7'b0_000_000, S0, S0, 1'b1, 1'b1);
    expect_perf(32'd5, 32'd5);
    step(7'b0_000_000, S0, S0, 1'b0, 1'b0);

    // Test 3: plain stall requests, wider mask wins.
    cur_id = 8'd3;
    step(7'b0_100_000, SID, S0, 1'b0, 1'b0);
    step(7'b0_110_000, SEX, S0, 1'b0, 1'b0);
    step(7'b0_010_000, SEX, S0, 1'b0, 1'b0);
    step(7'b0_000_000, S0,  S0, 1'b0, 1'b0);

    // Test 5: both starts -> MUL; starts during MUL ignored.
    cur_id = 8'd5;
    step(7'b0_001_100, SEX, S0, 1'b0, 1'b0);
    step(7'b0_000_100, SEX, S0, 1'b1, 1'b0);
    step(7'b0_001_100, SEX, S0, 1'b1, 1'b0);
    step(7'b0_000_100, SEX, S0, 1'b1, 1'b0);
    step(7'b0_000_100, SEX, S0, 1'b1, 1'b0);
    step(7'b0_000_000, S0,  S0, 1'b1, 1'b1);
    step(7'b0_000_000, S0,  S0, 1'b0, 1'b0);

    // Test 2: DIV ended early by md_ready in the 3rd busy cycle; ID request
    // still honoured in the completion cycle.
    cur_id = 8'd2;
    step(7'b0_000_100, SEX, S0, 1'b0, 1'b0);
    step(7'b0_000_000, SEX, S0, 1'b1, 1'b0);
    step(7'b0_000_000, SEX, S0, 1'b1, 1'b0);
    step(7'b0_100_010, SID, S0, 1'b1, 1'b1);
    step(7'b0_000_000, S0,  S0, 1'b0, 1'b0);

    // Test 4: flush mid-DIV at cnt=10 (22 DIV cycles after issue).
    cur_id = 8'd4;
    step(7'b0_000_100, SEX, S0, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) step(7'b0_000_000, SEX, S0, 1'b1, 1'b0);
    step(7'b0_010_001, S0, FAL, 1'b1, 1'b0);
    step(7'b0_000_000, S0, S0,  1'b0, 1'b0);
    // Flush in IDLE beats a MUL start: no op is launched.
    step(7'b0_001_001, S0, FAL, 1'b0, 1'b0);
    step(7'b0_000_000, S0, S0,  1'b0, 1'b0);

    // Reset mid-MUL: outputs low, no done pulse, IDLE afterwards, perf cleared.
    cur_id = 8'd6;
    step(7'b0_001_000, SEX, S0, 1'b0, 1'b0);
    step(7'b0_000_000, SEX, S0, 1'b1, 1'b0);
    step(7'b1_000_000, S0,  S0, 1'b0, 1'b0);
    expect_perf(32'd0, 32'd0);
    step(7'b0_000_000, S0,  S0, 1'b0, 1'b0);
    step(7'b0_000_000, S0,  S0, 1'b0, 1'b0);

    // Drain with a bounded wait.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) check("drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
